// File: rtl/cu_edge_data_read_control_pkg.sv
// Bus payload types shared by the edge data read control block and its users.
package cu_edge_data_read_control_pkg;

  localparam int unsigned AddrW  = 64;
  localparam int unsigned CuIdW  = 8;
  localparam int unsigned LaneW  = 4;
  localparam int unsigned SizeW  = 12;
  localparam int unsigned LineW  = 512;

  typedef enum logic [1:0] {
    CMD_INVALID = 2'd0,
    CMD_READ    = 2'd1,
    CMD_WRITE   = 2'd2
  } cmd_type_e;

  typedef enum logic [1:0] {
    STRUCT_INVALID   = 2'd0,
    EDGE_DATA_READ   = 2'd1,
    VERTEX_DATA_READ = 2'd2,
    EDGE_DATA_WRITE  = 2'd3
  } vertex_struct_e;

  typedef enum logic [2:0] {
    NOP        = 3'd0,
    READ_CL_NA = 3'd1,
    WRITE_NA   = 3'd2
  } command_e;

  typedef struct packed {
    logic                valid;
    logic [AddrW-1:0]    auxiliary1;
  } WEDInterface;

  typedef struct packed {
    logic                valid;
    logic [AddrW-1:0]    src;
    logic [AddrW-1:0]    dest;
  } EdgeInterface;

  // empty is the LSB so the idle/reset pattern is 4'b0001
  typedef struct packed {
    logic alfull;
    logic full;
    logic busy;
    logic empty;
  } BufferStatus;

  typedef struct packed {
    logic [CuIdW-1:0]    cu_id;
    cmd_type_e           cmd_type;
    vertex_struct_e      vertex_struct;
    logic [LaneW-1:0]    real_size;
  } CommandTag;

  typedef struct packed {
    logic                valid;
    command_e            command;
    logic [AddrW-1:0]    address;
    logic [SizeW-1:0]    size;
    CommandTag           cmd;
  } CommandBufferLine;

  typedef struct packed {
    logic                valid;
    CommandTag           cmd;
  } ResponseBufferLine;

  typedef struct packed {
    logic                valid;
    CommandTag           cmd;
    logic [LineW-1:0]    data;
  } ReadWriteDataLine;

endpackage

// File: rtl/cu_edge_data_read_control.sv
// Pops edges, issues 128-B vertex-data reads and returns the addressed 64-bit word.
module cu_edge_data_read_control
  import cu_edge_data_read_control_pkg::*;
#(
  parameter int unsigned CU_ID           = 1,
  parameter int unsigned MAX_OUTSTANDING = 16
) (
  input  logic              clock,
  input  logic              rstn,
  input  logic              enabled,
  input  WEDInterface       wed_request_in,
  input  EdgeInterface      edge_job,
  input  BufferStatus       edge_buffer_status,
  input  BufferStatus       read_command_buffer_status,
  input  ResponseBufferLine read_response_in,
  input  ReadWriteDataLine  read_data_0_in,
  input  ReadWriteDataLine  read_data_1_in,
  output logic              edge_request,
  output CommandBufferLine  read_command_out,
  output logic              edge_data_valid,
  output logic [63:0]       edge_data,
  output logic [31:0]       edges_processed
);

  localparam int unsigned DataW  = 64;
  localparam int unsigned CountW = 32;
  localparam int unsigned OutW   = 8;
  localparam logic [CuIdW-1:0] CuId   = CuIdW'(CU_ID);
  localparam logic [OutW-1:0]  MaxOut = OutW'(MAX_OUTSTANDING);

  typedef enum logic [2:0] {
    ST_RESET, ST_IDLE, ST_POP, ST_WAIT_EDGE, ST_SEND
  } state_e;

  state_e            state_q, state_d;
  WEDInterface       wed_q;
  EdgeInterface      edge_job_q;
  BufferStatus       edge_status_q, cmd_status_q;
  ResponseBufferLine resp_q;
  logic [LineW-1:0]  data0_q, data1_q;
  logic [AddrW-1:0]  dest_q, dest_d;
  logic [OutW-1:0]   outstanding_q, outstanding_d;

  logic              edge_request_q, edge_request_d;
  CommandBufferLine  read_command_q, read_command_d;
  logic              edge_data_valid_q;
  logic [DataW-1:0]  edge_data_q;
  logic [CountW-1:0] edges_processed_q;

  logic              data0_match_c, data1_match_c, resp_match_c;
  logic              accept_c, issue_c;
  logic [AddrW-1:0]  addr_c;
  logic [LaneW-1:0]  lane_c;
  logic [DataW-1:0]  word_c;
  logic              unused_c;

  // Read-data lines are only worth keeping when they belong to this unit's edge reads
  always_comb begin
    data0_match_c = read_data_0_in.valid && (read_data_0_in.cmd.cu_id == CuId) &&
                    (read_data_0_in.cmd.vertex_struct == EDGE_DATA_READ);
    data1_match_c = read_data_1_in.valid && (read_data_1_in.cmd.cu_id == CuId) &&
                    (read_data_1_in.cmd.vertex_struct == EDGE_DATA_READ);
  end

  // Input stage: every input lands in a register before any decision uses it
  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      wed_q         <= '0;
      edge_job_q    <= '0;
      edge_status_q <= BufferStatus'(4'b0001);
      cmd_status_q  <= BufferStatus'(4'b0001);
      resp_q        <= '0;
      data0_q       <= '0;
      data1_q       <= '0;
    end else if (enabled) begin
      wed_q         <= wed_request_in;
      edge_job_q    <= edge_job;
      edge_status_q <= edge_buffer_status;
      cmd_status_q  <= read_command_buffer_status;
      resp_q        <= read_response_in;
      if (data0_match_c) data0_q <= read_data_0_in.data;
      if (data1_match_c) data1_q <= read_data_1_in.data;
    end
  end

  // Response qualification; a response with nothing outstanding is stale and dropped
  always_comb begin
    resp_match_c = resp_q.valid && (resp_q.cmd.cu_id == CuId) &&
                   (resp_q.cmd.vertex_struct == EDGE_DATA_READ);
    accept_c     = resp_match_c && (outstanding_q != '0);
    issue_c      = (state_q == ST_SEND);
    lane_c       = resp_q.cmd.real_size;
    word_c       = lane_c[3] ? data1_q[{lane_c[2:0], 6'b0} +: DataW]
                             : data0_q[{lane_c[2:0], 6'b0} +: DataW];
    addr_c       = wed_q.auxiliary1 + (dest_q << 3);
  end

  // Outstanding tracking: issue and response in one cycle cancel out
  always_comb begin
    outstanding_d = outstanding_q;
    if (issue_c && !accept_c) begin
      outstanding_d = outstanding_q + OutW'(1);
    end else if (!issue_c && accept_c) begin
      outstanding_d = outstanding_q - OutW'(1);
    end
  end

  // Next-state and command generation
  always_comb begin
    state_d        = state_q;
    dest_d         = dest_q;
    edge_request_d = 1'b0;
    read_command_d = '0;
    case (state_q)
      ST_RESET: begin
        if (wed_q.valid) state_d = ST_IDLE;
      end
      ST_IDLE: begin
        if (!wed_q.valid) begin
          state_d = ST_RESET;
        end else if (!edge_status_q.empty && !cmd_status_q.alfull &&
                     (outstanding_q < MaxOut)) begin
          state_d = ST_POP;
        end
      end
      ST_POP: begin
        edge_request_d = 1'b1;
        state_d        = ST_WAIT_EDGE;
      end
      ST_WAIT_EDGE: begin
        if (edge_job_q.valid) begin
          dest_d  = edge_job_q.dest;
          state_d = ST_SEND;
        end
      end
      ST_SEND: begin
        read_command_d.valid             = 1'b1;
        read_command_d.command           = READ_CL_NA;
        read_command_d.size              = SizeW'(128);
        read_command_d.address           = {addr_c[AddrW-1:7], 7'b0};
        read_command_d.cmd.cu_id         = CuId;
        read_command_d.cmd.cmd_type      = CMD_READ;
        read_command_d.cmd.vertex_struct = EDGE_DATA_READ;
        read_command_d.cmd.real_size     = addr_c[6:3];
        state_d = wed_q.valid ? ST_IDLE : ST_RESET;
      end
      default: state_d = ST_RESET;
    endcase
  end

  // Control state registers
  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      state_q       <= ST_RESET;
      dest_q        <= '0;
      outstanding_q <= '0;
    end else if (enabled) begin
      state_q       <= state_d;
      dest_q        <= dest_d;
      outstanding_q <= outstanding_d;
    end
  end

  // Output registers
  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      edge_request_q    <= 1'b0;
      read_command_q    <= '0;
      edge_data_valid_q <= 1'b0;
      edge_data_q       <= '0;
      edges_processed_q <= '0;
    end else if (enabled) begin
      edge_request_q    <= edge_request_d;
      read_command_q    <= read_command_d;
      edge_data_valid_q <= accept_c;
      if (accept_c) begin
        edge_data_q       <= word_c;
        edges_processed_q <= edges_processed_q + CountW'(1);
      end
    end
  end

  assign edge_request     = edge_request_q;
  assign read_command_out = read_command_q;
  assign edge_data_valid  = edge_data_valid_q;
  assign edge_data        = edge_data_q;
  assign edges_processed  = edges_processed_q;

  // Fields carried on the buses that this block does not consume
  assign unused_c = ^{edge_status_q.alfull, edge_status_q.full, edge_status_q.busy,
                      cmd_status_q.full, cmd_status_q.busy, cmd_status_q.empty,
                      edge_job_q.src, resp_q.cmd.cmd_type,
                      read_data_0_in.cmd, read_data_1_in.cmd, addr_c[2:0]};

endmodule

// File: tb/tb_cu_edge_data_read_control.sv
// Directed bench for cu_edge_data_read_control: two instances (default depth, depth 2).
module tb_cu_edge_data_read_control;
  import cu_edge_data_read_control_pkg::*;

  logic clock = 1'b0;
  logic rstn  = 1'b0;
  logic en_a  = 1'b0;
  logic en_b  = 1'b0;

  WEDInterface       wed;
  EdgeInterface      edge_job = '0;
  BufferStatus       edge_status = 4'b0001;
  BufferStatus       cmd_status;
  ResponseBufferLine resp;
  ReadWriteDataLine  rd0, rd1;

  logic              a_edge_request, b_edge_request;
  CommandBufferLine  a_cmd, b_cmd;
  logic              a_dv, b_dv;
  logic [63:0]       a_data, b_data;
  logic [31:0]       a_edges, b_edges;

  int total = 0;
  int bad   = 0;
  int a_req_cnt = 0, b_req_cnt = 0, a_dv_cnt = 0, b_dv_cnt = 0;
  int dv_before;
  logic [63:0] fifo[$];
  CommandBufferLine a_cmdq[$], b_cmdq[$];

  cu_edge_data_read_control #(.CU_ID(1), .MAX_OUTSTANDING(16)) dut_a (
    .clock(clock), .rstn(rstn), .enabled(en_a),
    .wed_request_in(wed), .edge_job(edge_job),
    .edge_buffer_status(edge_status), .read_command_buffer_status(cmd_status),
    .read_response_in(resp), .read_data_0_in(rd0), .read_data_1_in(rd1),
    .edge_request(a_edge_request), .read_command_out(a_cmd),
    .edge_data_valid(a_dv), .edge_data(a_data), .edges_processed(a_edges)
  );

  cu_edge_data_read_control #(.CU_ID(3), .MAX_OUTSTANDING(2)) dut_b (
    .clock(clock), .rstn(rstn), .enabled(en_b),
    .wed_request_in(wed), .edge_job(edge_job),
    .edge_buffer_status(edge_status), .read_command_buffer_status(cmd_status),
    .read_response_in(resp), .read_data_0_in(rd0), .read_data_1_in(rd1),
    .edge_request(b_edge_request), .read_command_out(b_cmd),
    .edge_data_valid(b_dv), .edge_data(b_data), .edges_processed(b_edges)
  );

  always #5 clock = ~clock;

  // Upstream edge FIFO: one pop per observed edge_request pulse
  always @(negedge clock) begin
    edge_job = '0;
    if ((en_a && a_edge_request) || (en_b && b_edge_request)) begin
      if (fifo.size() > 0) begin
        edge_job.valid = 1'b1;
        edge_job.dest  = fifo.pop_front();
      end
    end
    edge_status       = '0;
    edge_status.empty = (fifo.size() == 0);
  end

  // Output monitor
  always @(negedge clock) begin
    if (en_a) begin
      if (a_edge_request) a_req_cnt++;
      if (a_cmd.valid) a_cmdq.push_back(a_cmd);
      if (a_dv) a_dv_cnt++;
    end
    if (en_b) begin
      if (b_edge_request) b_req_cnt++;
      if (b_cmd.valid) b_cmdq.push_back(b_cmd);
      if (b_dv) b_dv_cnt++;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic set_resp(input logic v, input logic [7:0] cu, input vertex_struct_e vs,
                          input logic [3:0] rs);
    resp.valid = v;
    resp.cmd.cu_id = cu;
    resp.cmd.cmd_type = CMD_READ;
    resp.cmd.vertex_struct = vs;
    resp.cmd.real_size = rs;
    rd0.valid = v;
    rd0.cmd   = resp.cmd;
    rd1.valid = v;
    rd1.cmd   = resp.cmd;
  endtask

  task automatic send_resp(input logic [7:0] cu, input vertex_struct_e vs, input logic [3:0] rs);
    set_resp(1'b1, cu, vs, rs);
    @(negedge clock);
    set_resp(1'b0, 8'd0, STRUCT_INVALID, 4'd0);
  endtask

  task automatic wait_a_cmds(input int n);
    for (int i = 0; i < 80 && a_cmdq.size() < n; i++) @(negedge clock);
    check("a_cmd_arrived", 64'(a_cmdq.size() >= n), 64'd1);
  endtask

  initial begin
    wed = '0;
    cmd_status = '0;
    resp = '0;
    rd0 = '0;
    rd1 = '0;
    for (int k = 0; k < 8; k++) begin
      rd0.data[64*k +: 64] = 64'h0A00_0000_0000_0000 + 64'(k);
      rd1.data[64*k +: 64] = 64'h0B00_0000_0000_0000 + 64'(k);
    end
    en_a = 1'b1;
    tick(3);

    // Reset values
    check("rst_edge_request", 64'(a_edge_request), 64'd0);
    check("rst_cmd_zero", 64'(|a_cmd), 64'd0);
    check("rst_dv", 64'(a_dv), 64'd0);
    check("rst_edge_data", a_data, 64'd0);
    check("rst_edges", 64'(a_edges), 64'd0);
    check("rst_outstanding", 64'(dut_a.outstanding_q), 64'd0);
    check("rst_edge_status", 64'(dut_a.edge_status_q), 64'd1);

    // Single edge dest=5, base 0x1000
    rstn = 1'b1;
    wed.valid = 1'b1;
    wed.auxiliary1 = 64'h1000;
    fifo.push_back(64'd5);
    wait_a_cmds(1);
    check("c1_address", a_cmdq[0].address, 64'h1000);
    check("c1_real_size", 64'(a_cmdq[0].cmd.real_size), 64'd5);
    check("c1_size", 64'(a_cmdq[0].size), 64'd128);
    check("c1_cu_id", 64'(a_cmdq[0].cmd.cu_id), 64'd1);
    check("c1_command", 64'(a_cmdq[0].command), 64'(READ_CL_NA));
    check("c1_vstruct", 64'(a_cmdq[0].cmd.vertex_struct), 64'(EDGE_DATA_READ));
    check("c1_cmd_type", 64'(a_cmdq[0].cmd.cmd_type), 64'(CMD_READ));
    tick(10);
    check("c1_one_pop", 64'(a_req_cnt), 64'd1);
    check("c1_one_cmd", 64'(a_cmdq.size()), 64'd1);
    check("c1_idle_cmd_zero", 64'(|a_cmd), 64'd0);
    check("c1_outstanding", 64'(dut_a.outstanding_q), 64'd1);

    // dest=20 -> 0x10A0, aligned 0x1080, lane 4
    fifo.push_back(64'd20);
    wait_a_cmds(2);
    check("c2_address", a_cmdq[1].address, 64'h1080);
    check("c2_real_size", 64'(a_cmdq[1].cmd.real_size), 64'd4);
    tick(2);
    check("c2_outstanding", 64'(dut_a.outstanding_q), 64'd2);
    rd0.data[256 +: 64] = 64'hDEAD_BEEF_0000_0001;
    rd1.data[256 +: 64] = 64'hDEAD_BEEF_0000_0001;
    send_resp(8'd1, EDGE_DATA_READ, 4'd4);
    check("r1_not_yet", 64'(a_dv), 64'd0);
    tick(1);
    check("r1_dv", 64'(a_dv), 64'd1);
    check("r1_data", a_data, 64'hDEAD_BEEF_0000_0001);
    check("r1_edges", 64'(a_edges), 64'd1);
    check("r1_outstanding", 64'(dut_a.outstanding_q), 64'd1);
    tick(1);
    check("r1_dv_one_cycle", 64'(a_dv), 64'd0);

    // Lane 12 comes from the upper half line
    rd0.data[256 +: 64] = 64'h5555_6666_7777_8888;
    rd1.data[256 +: 64] = 64'h1111_2222_3333_4444;
    send_resp(8'd1, EDGE_DATA_READ, 4'd12);
    tick(1);
    check("r2_data_lane12", a_data, 64'h1111_2222_3333_4444);
    check("r2_edges", 64'(a_edges), 64'd2);
    check("r2_outstanding", 64'(dut_a.outstanding_q), 64'd0);

    // Foreign cu_id and wrong structure are ignored
    fifo.push_back(64'd1);
    wait_a_cmds(3);
    tick(2);
    dv_before = a_dv_cnt;
    send_resp(8'd2, EDGE_DATA_READ, 4'd0);
    send_resp(8'd1, VERTEX_DATA_READ, 4'd0);
    tick(3);
    check("r3_foreign_no_dv", 64'(a_dv_cnt), 64'(dv_before));
    check("r3_foreign_outstanding", 64'(dut_a.outstanding_q), 64'd1);
    check("r3_data_held", a_data, 64'h1111_2222_3333_4444);

    // Command issue and matching response in the same cycle
    fifo.push_back(64'd2);
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (a_edge_request) break;
    end
    check("r4_saw_pop", 64'(a_edge_request), 64'd1);
    @(negedge clock);
    set_resp(1'b1, 8'd1, EDGE_DATA_READ, 4'd7);
    @(negedge clock);
    set_resp(1'b0, 8'd0, STRUCT_INVALID, 4'd0);
    @(negedge clock);
    check("r4_cmd_valid", 64'(a_cmd.valid), 64'd1);
    check("r4_dv", 64'(a_dv), 64'd1);
    check("r4_data_lane7", a_data, 64'h0A00_0000_0000_0007);
    check("r4_outstanding_same", 64'(dut_a.outstanding_q), 64'd1);

    // Reset with three outstanding, then a stale response
    fifo.push_back(64'd3);
    fifo.push_back(64'd4);
    wait_a_cmds(6);
    tick(3);
    check("r5_outstanding3", 64'(dut_a.outstanding_q), 64'd3);
    dv_before = a_dv_cnt;
    rstn = 1'b0;
    #1;
    check("r5_rst_req", 64'(a_edge_request), 64'd0);
    check("r5_rst_cmd", 64'(|a_cmd), 64'd0);
    check("r5_rst_dv", 64'(a_dv), 64'd0);
    check("r5_rst_data", a_data, 64'd0);
    check("r5_rst_edges", 64'(a_edges), 64'd0);
    check("r5_rst_outstanding", 64'(dut_a.outstanding_q), 64'd0);
    @(negedge clock);
    rstn = 1'b1;
    tick(3);
    send_resp(8'd1, EDGE_DATA_READ, 4'd0);
    tick(4);
    check("r5_stale_no_dv", 64'(a_dv_cnt), 64'(dv_before));
    check("r5_no_underflow", 64'(dut_a.outstanding_q), 64'd0);
    check("r5_edges_zero", 64'(a_edges), 64'd0);
    check("r5_no_new_cmd", 64'(a_cmdq.size()), 64'd6);

    // Depth-2 instance: five edges, no responses
    en_a = 1'b0;
    en_b = 1'b1;
    for (int d = 10; d < 15; d++) fifo.push_back(64'(d));
    tick(80);
    check("b_two_cmds", 64'(b_cmdq.size()), 64'd2);
    check("b_two_pops", 64'(b_req_cnt), 64'd2);
    check("b_fifo_left", 64'(fifo.size()), 64'd3);
    check("b_outstanding_max", 64'(dut_b.outstanding_q), 64'd2);
    check("b_c0_cu_id", 64'(b_cmdq[0].cmd.cu_id), 64'd3);
    check("b_c0_address", b_cmdq[0].address, 64'h1000);
    check("b_c1_real_size", 64'(b_cmdq[1].cmd.real_size), 64'd11);
    check("a_held_edges", 64'(a_edges), 64'd0);
    send_resp(8'd3, EDGE_DATA_READ, 4'd0);
    tick(60);
    check("b_one_more_cmd", 64'(b_cmdq.size()), 64'd3);
    check("b_c2_real_size", 64'(b_cmdq[2].cmd.real_size), 64'd12);
    check("b_fifo_left2", 64'(fifo.size()), 64'd2);
    check("b_dv_count", 64'(b_dv_cnt), 64'd1);
    check("b_outstanding_max2", 64'(dut_b.outstanding_q), 64'd2);

    // WED drops: no new commands, outstanding response still delivered
    wed.valid = 1'b0;
    tick(5);
    send_resp(8'd3, EDGE_DATA_READ, 4'd1);
    tick(40);
    check("b_wed_no_cmd", 64'(b_cmdq.size()), 64'd3);
    check("b_wed_dv", 64'(b_dv_cnt), 64'd2);
    check("b_wed_edges", 64'(b_edges), 64'd2);
    check("b_wed_outstanding", 64'(dut_b.outstanding_q), 64'd1);
    check("b_wed_fifo", 64'(fifo.size()), 64'd2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
